eth_mdio_ctrl: RTL and testbench

//  Command sequencer directly upstream of eth_mdio. Accepts host register read/write requests,

---
 rtl/eth_mdio_pkg.sv | 33 +++
 rtl/eth_mdio_poll_timer.sv | 41 ++++
 rtl/eth_mdio_ctrl.sv | 162 ++++++++++++++++
 tb/tb_eth_mdio_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mdio_pkg.sv
// Shared types and helpers for the MDIO command sequencer.
//   mdio_state_t : sequencer FSM states
//   MDIO_OP_*    : clause-22 opcode field values
//   MDIO_ST/TA   : start-of-frame and turnaround field values
//   mdio_frame() : assembles the 32-bit frame handed to eth_mdio
package eth_mdio_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FRAME_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } mdio_state_t;

    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_TA    = 2'b10;

    function automatic logic [FRAME_W-1:0] mdio_frame(
        input logic [1:0]        op,
        input logic [ADDR_W-1:0] phy,
        input logic [ADDR_W-1:0] regad,
        input logic [DATA_W-1:0] data
    );
        return {MDIO_ST, op, phy, regad, MDIO_TA, data};
    endfunction

endpackage

// File: rtl/eth_mdio_poll_timer.sv
// Free-running poll interval timer.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : poll has been issued, drop the pending request
//   o_pend     : a poll is owed to the PHY
// POLL_CYCLES = 0 freezes the counter and never requests a poll.
module eth_mdio_poll_timer #(
    parameter int unsigned POLL_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_pend
);

    localparam int unsigned CNT_W  = 32;
    localparam logic [CNT_W-1:0] RELOAD =
        (POLL_CYCLES == 0) ? '0 : CNT_W'(POLL_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             w_expire;

    assign w_expire = (POLL_CYCLES != 0) && (r_cnt == '0);

    // Expiry wins over a same-cycle clear so a fresh interval is never lost;
    // repeated expiries while pending simply keep the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= RELOAD;
            r_pend <= 1'b0;
        end else begin
            if (POLL_CYCLES != 0) begin
                r_cnt <= w_expire ? RELOAD : (r_cnt - CNT_W'(1));
            end
            r_pend <= w_expire | (r_pend & ~i_clr);
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/eth_mdio_ctrl.sv
// MDIO command sequencer sitting in front of eth_mdio.
// Serialises host register reads/writes and periodic link-status polls into
// single eth_mdio transactions, one outstanding at a time.
//   clk, rst_n                      : clock, synchronous active-low reset
//   cmd_valid/ready/write/phy/reg/wdata : host request handshake and payload
//   rsp_valid, rsp_rdata            : completion pulse and held read data
//   link_up, link_change            : polled link status and change pulse
//   do_read, do_write, txdata       : start pulses and frame to eth_mdio
//   rxdata, busy                    : read data and activity from eth_mdio
module eth_mdio_ctrl
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [4:0]  POLL_REG    = 5'd1,
    parameter int unsigned LINK_BIT    = 2,
    parameter int unsigned POLL_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_phy,
    input  logic [ADDR_W-1:0]  cmd_reg,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               link_up,
    output logic               link_change,
    output logic               do_read,
    output logic               do_write,
    output logic [FRAME_W-1:0] txdata,
    input  logic [DATA_W-1:0]  rxdata,
    input  logic               busy
);

    mdio_state_t        r_state,       w_nxt_state;
    logic [FRAME_W-1:0] r_txdata,      w_nxt_txdata;
    logic               r_do_read,     w_nxt_do_read;
    logic               r_do_write,    w_nxt_do_write;
    logic               r_rsp_valid,   w_nxt_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata,   w_nxt_rsp_rdata;
    logic               r_link_up,     w_nxt_link_up;
    logic               r_link_change, w_nxt_link_change;
    logic               r_is_poll,     w_nxt_is_poll;
    logic               r_is_write,    w_nxt_is_write;
    logic               w_cmd_ready;
    logic               w_poll_start;
    logic               w_poll_pend;
    logic               w_link_bit;

    eth_mdio_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_poll_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_poll_start),
        .o_pend (w_poll_pend)
    );

    assign w_link_bit = rxdata[LINK_BIT];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_txdata      <= '0;
            r_do_read     <= 1'b0;
            r_do_write    <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_link_up     <= 1'b0;
            r_link_change <= 1'b0;
            r_is_poll     <= 1'b0;
            r_is_write    <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_txdata      <= w_nxt_txdata;
            r_do_read     <= w_nxt_do_read;
            r_do_write    <= w_nxt_do_write;
            r_rsp_valid   <= w_nxt_rsp_valid;
            r_rsp_rdata   <= w_nxt_rsp_rdata;
            r_link_up     <= w_nxt_link_up;
            r_link_change <= w_nxt_link_change;
            r_is_poll     <= w_nxt_is_poll;
            r_is_write    <= w_nxt_is_write;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_txdata      = r_txdata;
        w_nxt_do_read     = 1'b0;
        w_nxt_do_write    = 1'b0;
        w_nxt_rsp_valid   = 1'b0;
        w_nxt_rsp_rdata   = r_rsp_rdata;
        w_nxt_link_up     = r_link_up;
        w_nxt_link_change = 1'b0;
        w_nxt_is_poll     = r_is_poll;
        w_nxt_is_write    = r_is_write;
        w_cmd_ready       = 1'b0;
        w_poll_start      = 1'b0;

        unique case (r_state)
            IDLE: begin
                // busy may still be high from a transaction cut short by reset
                w_cmd_ready = rst_n && !busy;
                if (cmd_valid && w_cmd_ready) begin
                    w_nxt_txdata   = mdio_frame(cmd_write ? MDIO_OP_WR : MDIO_OP_RD,
                                                cmd_phy, cmd_reg,
                                                cmd_write ? cmd_wdata : '0);
                    w_nxt_is_poll  = 1'b0;
                    w_nxt_is_write = cmd_write;
                    w_nxt_do_write = cmd_write;
                    w_nxt_do_read  = !cmd_write;
                    w_nxt_state    = ISSUE;
                end else if (w_poll_pend && !busy) begin
                    w_nxt_txdata   = mdio_frame(MDIO_OP_RD, PHY_ADDR, POLL_REG, '0);
                    w_nxt_is_poll  = 1'b1;
                    w_nxt_is_write = 1'b0;
                    w_nxt_do_read  = 1'b1;
                    w_poll_start   = 1'b1;
                    w_nxt_state    = ISSUE;
                end
            end
            ISSUE: begin
                w_nxt_state = WAIT_START;
            end
            WAIT_START: begin
                if (busy) begin
                    w_nxt_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    w_nxt_state = IDLE;
                    if (r_is_poll) begin
                        w_nxt_link_up     = w_link_bit;
                        w_nxt_link_change = (w_link_bit != r_link_up);
                    end else begin
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = r_is_write ? '0 : rxdata;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign link_up     = r_link_up;
    assign link_change = r_link_change;
    assign do_read     = r_do_read;
    assign do_write    = r_do_write;
    assign txdata      = r_txdata;

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Directed bench for eth_mdio_ctrl.
// Instance A has polling disabled and carries the host-path tests; instance B
// polls every 200 cycles and carries the link-status and collision tests.
// Each instance is paired with a behavioural eth_mdio: busy rises one cycle
// after a start pulse and stays high for 64 cycles.
module tb_eth_mdio_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: POLL_CYCLES = 0 ----------------
    logic        a_rst_n, a_cmd_valid, a_cmd_ready, a_cmd_write;
    logic [4:0]  a_cmd_phy, a_cmd_reg;
    logic [15:0] a_cmd_wdata, a_rsp_rdata, a_rxdata;
    logic        a_rsp_valid, a_link_up, a_link_change, a_do_read, a_do_write;
    logic [31:0] a_txdata;
    logic        a_busy = 1'b0;
    int          a_bcnt = 0;

    eth_mdio_ctrl #(
        .PHY_ADDR (5'd1), .POLL_REG (5'd1), .LINK_BIT (2), .POLL_CYCLES (0)
    ) u_dut_a (
        .clk (clk), .rst_n (a_rst_n),
        .cmd_valid (a_cmd_valid), .cmd_ready (a_cmd_ready), .cmd_write (a_cmd_write),
        .cmd_phy (a_cmd_phy), .cmd_reg (a_cmd_reg), .cmd_wdata (a_cmd_wdata),
        .rsp_valid (a_rsp_valid), .rsp_rdata (a_rsp_rdata),
        .link_up (a_link_up), .link_change (a_link_change),
        .do_read (a_do_read), .do_write (a_do_write), .txdata (a_txdata),
        .rxdata (a_rxdata), .busy (a_busy)
    );

    always @(posedge clk) begin
        if (a_do_read || a_do_write) begin
            a_busy <= 1'b1;
            a_bcnt <= 63;
        end else if (a_busy) begin
            if (a_bcnt == 0) a_busy <= 1'b0;
            else             a_bcnt <= a_bcnt - 1;
        end
    end

    int a_n_rd = 0, a_n_wr = 0, a_n_rsp = 0, a_n_lchg = 0;
    always @(posedge clk) begin
        if (a_do_read)     a_n_rd   <= a_n_rd + 1;
        if (a_do_write)    a_n_wr   <= a_n_wr + 1;
        if (a_rsp_valid)   a_n_rsp  <= a_n_rsp + 1;
        if (a_link_change) a_n_lchg <= a_n_lchg + 1;
    end

    // ---------------- instance B: POLL_CYCLES = 200 ----------------
    logic        b_rst_n, b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [4:0]  b_cmd_phy, b_cmd_reg;
    logic [15:0] b_cmd_wdata, b_rsp_rdata, b_rxdata;
    logic        b_rsp_valid, b_link_up, b_link_change, b_do_read, b_do_write;
    logic [31:0] b_txdata;
    logic        b_busy = 1'b0;
    int          b_bcnt = 0;

    eth_mdio_ctrl #(
        .PHY_ADDR (5'd1), .POLL_REG (5'd1), .LINK_BIT (2), .POLL_CYCLES (200)
    ) u_dut_b (
        .clk (clk), .rst_n (b_rst_n),
        .cmd_valid (b_cmd_valid), .cmd_ready (b_cmd_ready), .cmd_write (b_cmd_write),
        .cmd_phy (b_cmd_phy), .cmd_reg (b_cmd_reg), .cmd_wdata (b_cmd_wdata),
        .rsp_valid (b_rsp_valid), .rsp_rdata (b_rsp_rdata),
        .link_up (b_link_up), .link_change (b_link_change),
        .do_read (b_do_read), .do_write (b_do_write), .txdata (b_txdata),
        .rxdata (b_rxdata), .busy (b_busy)
    );

    always @(posedge clk) begin
        if (b_do_read || b_do_write) begin
            b_busy <= 1'b1;
            b_bcnt <= 63;
        end else if (b_busy) begin
            if (b_bcnt == 0) b_busy <= 1'b0;
            else             b_bcnt <= b_bcnt - 1;
        end
    end

    // Log of every start pulse on B: frame, direction, cycle stamp.
    logic [31:0] b_q_tx[$];
    bit          b_q_wr[$];
    int          b_q_cyc[$];
    int b_n_rd = 0, b_n_rsp = 0, b_n_lchg = 0;
    always @(posedge clk) begin
        if (b_do_read || b_do_write) begin
            b_q_tx.push_back(b_txdata);
            b_q_wr.push_back(b_do_write);
            b_q_cyc.push_back(cyc);
        end
        if (b_do_read)     b_n_rd   <= b_n_rd + 1;
        if (b_rsp_valid)   b_n_rsp  <= b_n_rsp + 1;
        if (b_link_change) b_n_lchg <= b_n_lchg + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b_tx_at(input int idx);
        return (idx < b_q_tx.size()) ? b_q_tx[idx] : 32'hxxxx_xxxx;
    endfunction

    task automatic wait_b_lchg(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (b_link_change) seen = 1'b1;
        end
        check({tag, "_lchg_seen"}, 32'(seen), 32'd1);
    endtask

    // One host transaction on A from request to completion.
    task automatic host_a(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, input string tag,
                          input logic [31:0] exp_tx, input logic [15:0] exp_rd);
        int rd0 = a_n_rd;
        int wr0 = a_n_wr;
        int rsp0 = a_n_rsp;
        bit ready_hi = 1'b0;
        bit seen_busy = 1'b0;
        bit done = 1'b0;
        int fall_at = -1;
        int lat = -1;
        check({tag, "_ready"}, 32'(a_cmd_ready), 32'd1);
        a_cmd_valid = 1'b1; a_cmd_write = wr; a_cmd_phy = phy; a_cmd_reg = rg; a_cmd_wdata = wd;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        check({tag, "_pulse"}, 32'(wr ? a_do_write : a_do_read), 32'd1);
        check({tag, "_txdata"}, a_txdata, exp_tx);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (a_busy) seen_busy = 1'b1;
            else if (seen_busy && fall_at < 0) fall_at = i;
            if (a_rsp_valid) begin
                done = 1'b1;
                lat  = i - fall_at;
            end else if (a_cmd_ready) begin
                ready_hi = 1'b1;
            end
        end
        check({tag, "_rsp_seen"}, 32'(done), 32'd1);
        check({tag, "_rsp_lat"}, 32'(lat), 32'd1);
        check({tag, "_rdata"}, 32'(a_rsp_rdata), 32'(exp_rd));
        check({tag, "_ready_low"}, 32'(ready_hi), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_pulse"}, 32'(a_rsp_valid), 32'd0);
        check({tag, "_n_rd"}, 32'(a_n_rd - rd0), wr ? 32'd0 : 32'd1);
        check({tag, "_n_wr"}, 32'(a_n_wr - wr0), wr ? 32'd1 : 32'd0);
        check({tag, "_n_rsp"}, 32'(a_n_rsp - rsp0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        bit bad;
        int n0;
        int snap;

        a_rst_n = 1'b0; a_cmd_valid = 1'b0; a_cmd_write = 1'b0;
        a_cmd_phy = '0; a_cmd_reg = '0; a_cmd_wdata = '0; a_rxdata = '0;
        b_rst_n = 1'b0; b_cmd_valid = 1'b0; b_cmd_write = 1'b0;
        b_cmd_phy = '0; b_cmd_reg = '0; b_cmd_wdata = '0; b_rxdata = 16'h0004;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctl_a", 32'({a_do_read, a_do_write, a_rsp_valid, a_link_up,
                                 a_link_change, a_cmd_ready}), 32'd0);
        check("rst_tx_a", a_txdata, 32'd0);
        check("rst_rdata_a", 32'(a_rsp_rdata), 32'd0);
        check("rst_ctl_b", 32'({b_do_read, b_do_write, b_rsp_valid, b_link_up,
                                 b_link_change, b_cmd_ready}), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready_a", 32'(a_cmd_ready), 32'd1);

        // Link polling on B: BMSR bit 2 set, then cleared.
        // Poll frame: 01 10 00001 00001 10 -> 16'h6086, data 0.
        wait_b_lchg(500, "poll1");
        @(negedge clk);
        check("poll1_link", 32'(b_link_up), 32'd1);
        check("poll1_nlchg", 32'(b_n_lchg), 32'd1);
        check("poll1_nrd", 32'(b_n_rd), 32'd1);
        check("poll1_frame", b_tx_at(0), 32'h6086_0000);
        b_rxdata = 16'h0000;
        wait_b_lchg(500, "poll2");
        @(negedge clk);
        check("poll2_link", 32'(b_link_up), 32'd0);
        check("poll2_nlchg", 32'(b_n_lchg), 32'd2);
        check("poll2_frame", b_tx_at(1), 32'h6086_0000);
        check("poll_interval", 32'(b_q_cyc.size() >= 2 ? b_q_cyc[1] - b_q_cyc[0] : -1), 32'd200);
        repeat (250) @(negedge clk);
        check("poll3_nolchg", 32'(b_n_lchg), 32'd2);
        check("poll3_ran", 32'(b_n_rd >= 3), 32'd1);
        check("poll_no_rsp", 32'(b_n_rsp), 32'd0);

        // Host request on B lands on the same edge as a timer expiry.
        // A poll pulse follows expiry by one edge, so expiry recurs 199 edges later.
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (b_do_read) seen = 1'b1;
        end
        check("coll_sync", 32'(seen), 32'd1);
        repeat (198) @(negedge clk);
        n0 = b_q_tx.size();
        check("coll_ready", 32'(b_cmd_ready), 32'd1);
        b_cmd_valid = 1'b1; b_cmd_write = 1'b1;
        b_cmd_phy = 5'd5; b_cmd_reg = 5'd4; b_cmd_wdata = 16'h1234;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        repeat (150) @(negedge clk);
        // Host frame: 01 01 00101 00100 10 -> 16'h5292
        check("coll_first_tx", b_tx_at(n0), 32'h5292_1234);
        check("coll_first_wr", 32'(b_q_wr.size() > n0 ? b_q_wr[n0] : 1'b0), 32'd1);
        check("coll_second_tx", b_tx_at(n0 + 1), 32'h6086_0000);
        check("coll_second_rd", 32'(b_q_wr.size() > n0 + 1 ? b_q_wr[n0 + 1] : 1'b1), 32'd0);
        // write pulse, 1 to busy, 64 busy, 1 to IDLE, 1 to next pulse
        check("coll_gap", 32'(b_q_cyc.size() > n0 + 1 ? b_q_cyc[n0 + 1] - b_q_cyc[n0] : -1), 32'd67);
        check("coll_rsp", 32'(b_n_rsp), 32'd1);
        check("coll_rdata", 32'(b_rsp_rdata), 32'd0);

        // Host read on A. Frame: 01 10 00001 00010 10 -> 16'h608A
        a_rxdata = 16'h0141;
        host_a(1'b0, 5'd1, 5'd2, 16'hFFFF, "hrd", 32'h608A_0000, 16'h0141);
        // Host write on A. Frame: 01 01 00011 00000 10 -> 16'h5182
        a_rxdata = 16'hA5A5;
        host_a(1'b1, 5'd3, 5'd0, 16'h8000, "hwr", 32'h5182_8000, 16'h0000);

        // Reset while A's transaction is in WAIT_DONE.
        a_rxdata = 16'hBEEF;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_phy = 5'd2; a_cmd_reg = 5'd3;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        snap = a_n_rsp;
        a_rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ctl", 32'({a_do_read, a_do_write, a_rsp_valid, a_link_up,
                                   a_link_change, a_cmd_ready}), 32'd0);
        check("mid_rst_tx", a_txdata, 32'd0);
        a_rst_n = 1'b1;
        n0 = a_n_wr;
        a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_phy = 5'd4; a_cmd_reg = 5'd5;
        a_cmd_wdata = 16'h00FF;
        bad = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!a_busy) seen = 1'b1;
            else if (a_cmd_ready || a_do_write || a_do_read) bad = 1'b1;
        end
        a_cmd_valid = 1'b0;
        check("mid_busy_fell", 32'(seen), 32'd1);
        check("mid_no_accept", 32'(bad), 32'd0);
        check("mid_no_wr", 32'(a_n_wr - n0), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_lost_rsp", 32'(a_n_rsp - snap), 32'd0);
        // Frame: 01 01 00100 00101 10 -> 16'h5216
        host_a(1'b1, 5'd4, 5'd5, 16'h00FF, "post_rst", 32'h5216_00FF, 16'h0000);

        // Polling disabled: long idle run on A.
        snap = a_n_rd;
        repeat (32768) @(negedge clk);
        check("nopoll_rd", 32'(a_n_rd - snap), 32'd0);
        check("nopoll_total_rd", 32'(a_n_rd), 32'd2);
        check("nopoll_link", 32'(a_link_up), 32'd0);
        check("nopoll_lchg", 32'(a_n_lchg), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
